// File: rtl/evm_disp_pkg.sv
// Shared glyph encodings and snapshot layout for the EVM seven-segment display driver.
// Segment constants are active-high with segment a on bit 6 and segment g on bit 0.
package evm_disp_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [3:0] {
        G0, G1, G2, G3, G4, G5, G6, G7, G8, G9,
        G_BLANK, G_DASH, G_P, G_C
    } glyph_t;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_P     = 7'b1100111;
    localparam logic [6:0] SEG_C     = 7'b1001110;

    typedef struct packed {
        logic       result_mode;
        logic [3:0] vote;
        logic [1:0] cand;
        logic [1:0] tens;
        logic [3:0] ones;
        logic       overflow;
    } snap_t;

    // Values outside 0..9 have no numeric glyph and show as a dash.
    function automatic glyph_t digit_glyph(input logic [3:0] d);
        return (d > 4'd9) ? G_DASH : glyph_t'(d);
    endfunction

endpackage

// File: rtl/evm_seg_decoder.sv
// Combinational glyph to active-high segment pattern (seg[6] = a ... seg[0] = g).
module evm_seg_decoder
    import evm_disp_pkg::*;
(
    input  glyph_t     glyph,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (glyph)
            G0:      seg = SEG_0;
            G1:      seg = SEG_1;
            G2:      seg = SEG_2;
            G3:      seg = SEG_3;
            G4:      seg = SEG_4;
            G5:      seg = SEG_5;
            G6:      seg = SEG_6;
            G7:      seg = SEG_7;
            G8:      seg = SEG_8;
            G9:      seg = SEG_9;
            G_DASH:  seg = SEG_DASH;
            G_P:     seg = SEG_P;
            G_C:     seg = SEG_C;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/evm_display_driver.sv
// 4-digit multiplexed seven-segment driver for the voting core; inputs are snapshotted once per frame.
// Optional overflow blinking is enabled by defining EVM_DISP_BLINK_EN.
module evm_display_driver
    import evm_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       result_mode,
    input  logic [3:0] vote,
    input  logic [1:0] cand,
    input  logic [1:0] tens,
    input  logic [3:0] ones,
    input  logic       overflow,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int              DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [1:0]            digit_idx;
    snap_t                 snapshot;
    snap_t                 live_in;
    logic                  tick;
    logic                  frame_end;
    logic                  blank_all;
    logic                  dp_force;
    glyph_t                glyph;
    logic                  dp_on;
    logic [NUM_DIGITS-1:0] an_on;
    logic [6:0]            seg_on;

    assign tick      = (div_cnt == DIV_LAST);
    assign frame_end = tick && (digit_idx == 2'd3);
    assign live_in   = '{result_mode: result_mode, vote: vote, cand: cand,
                         tens: tens, ones: ones, overflow: overflow};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            digit_idx <= 2'd0;
            snapshot  <= '0;
        end else if (tick) begin
            div_cnt   <= '0;
            digit_idx <= digit_idx + 2'd1;
            if (frame_end) begin
                snapshot <= live_in;
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

`ifdef EVM_DISP_BLINK_EN
    localparam int                FRAME_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [FRAME_W-1:0] frame_cnt;
    logic               blink_phase;

    // The newly captured overflow decides the phase, so clearing it relights from the next frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FRAME_W'(1);
            if (!overflow) begin
                blink_phase <= 1'b0;
            end else if (frame_cnt == FRAME_LAST) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

    assign blank_all = snapshot.overflow & blink_phase;
    assign dp_force  = 1'b0;
`else
    assign blank_all = 1'b0;
    assign dp_force  = snapshot.overflow;
`endif

    always_comb begin
        glyph = G_BLANK;
        dp_on = 1'b0;
        an_on = NUM_DIGITS'(1) << digit_idx;
        if (snapshot.result_mode) begin
            case (digit_idx)
                2'd3: glyph = G_C;
                2'd2: begin
                    glyph = digit_glyph({2'b00, snapshot.cand} + 4'd1);
                    dp_on = 1'b1;
                end
                2'd1: glyph = (snapshot.tens == 2'd0) ? G_BLANK
                                                       : digit_glyph({2'b00, snapshot.tens});
                default: glyph = digit_glyph(snapshot.ones);
            endcase
        end else begin
            case (digit_idx)
                2'd3: glyph = G_P;
                2'd0: begin
                    case (snapshot.vote)
                        4'b0001: glyph = G1;
                        4'b0010: glyph = G2;
                        4'b0100: glyph = G3;
                        4'b1000: glyph = G4;
                        4'b0000: glyph = G_DASH;
                        default: begin
                            glyph = G_DASH;
                            dp_on = 1'b1;
                        end
                    endcase
                end
                default: glyph = G_BLANK;
            endcase
        end
        if (blank_all) begin
            an_on = '0;
        end
        if (dp_force) begin
            dp_on = 1'b1;
        end
    end

    evm_seg_decoder u_seg_decoder (
        .glyph (glyph),
        .seg   (seg_on)
    );

    // Polarity is folded in here only; everything upstream is active-high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            an  <= {4{ACTIVE_LOW}};
            seg <= {7{ACTIVE_LOW}};
            dp  <= ACTIVE_LOW;
        end else begin
            an  <= an_on ^ {4{ACTIVE_LOW}};
            seg <= seg_on ^ {7{ACTIVE_LOW}};
            dp  <= dp_on ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_evm_display_driver.sv
// Bench for evm_display_driver: cycle-count display model with an expected queue plus literal checks.
// Builds with or without EVM_DISP_BLINK_EN; the model follows the same macro.
module tb_evm_display_driver;

    localparam int RD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = 4 * RD;

    logic       clock       = 1'b0;
    logic       reset_n     = 1'b0;
    logic       result_mode = 1'b0;
    logic [3:0] vote        = 4'd0;
    logic [1:0] cand        = 2'd0;
    logic [1:0] tens        = 2'd0;
    logic [3:0] ones        = 4'd0;
    logic       overflow    = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    // clock / reset
    always #5 clock = ~clock;

    evm_display_driver #(
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .result_mode (result_mode),
        .vote        (vote),
        .cand        (cand),
        .tens        (tens),
        .ones        (ones),
        .overflow    (overflow),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    // model state: edges since reset release, frames completed, captured snapshot
    int         m_edges  = 0;
    int         m_frames = 0;
    logic       m_mode   = 1'b0;
    logic [3:0] m_vote   = 4'd0;
    logic [1:0] m_cand   = 2'd0;
    logic [1:0] m_tens   = 2'd0;
    logic [3:0] m_ones   = 4'd0;
    logic       m_ov     = 1'b0;
    logic       m_bp     = 1'b0;
    logic [11:0] exp_q[$];

    localparam logic [11:0] ALL_OFF = {4'hF, 7'h7F, 1'b1};

    // active-high segments a..g for digits 0-9, 10 blank, 11 dash, 12 P, 13 C
    function automatic logic [6:0] glyph_seg(int g);
        case (g)
            0:  return 7'b1111110;
            1:  return 7'b0110000;
            2:  return 7'b1101101;
            3:  return 7'b1111001;
            4:  return 7'b0110011;
            5:  return 7'b1011011;
            6:  return 7'b1011111;
            7:  return 7'b1110000;
            8:  return 7'b1111111;
            9:  return 7'b1111011;
            11: return 7'b0000001;
            12: return 7'b1100111;
            13: return 7'b1001110;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [11:0] model_out(int d);
        int         g;
        bit         dpo;
        logic [3:0] an_on;
        g   = 10;
        dpo = 1'b0;
        if (m_mode) begin
            case (d)
                3: g = 13;
                2: begin g = int'(m_cand) + 1; dpo = 1'b1; end
                1: g = (m_tens == 0) ? 10 : int'(m_tens);
                default: g = (m_ones > 9) ? 11 : int'(m_ones);
            endcase
        end else begin
            case (d)
                3: g = 12;
                0: begin
                    if ($countones(m_vote) == 1) g = $clog2(m_vote) + 1;
                    else begin g = 11; dpo = ($countones(m_vote) > 1); end
                end
                default: g = 10;
            endcase
        end
        an_on = 4'b0001 << d;
`ifdef EVM_DISP_BLINK_EN
        if (m_ov && m_bp) an_on = 4'b0000;
`else
        if (m_ov) dpo = 1'b1;
`endif
        return {~an_on, ~glyph_seg(g), ~dpo};
    endfunction

    // model: output after edge n shows digit ((n-1)/RD)%4 of the snapshot taken at edge FRAME*k
    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_edges  = 0;
                m_frames = 0;
                {m_mode, m_vote, m_cand, m_tens, m_ones, m_ov, m_bp} = '0;
                exp_q.delete();
                exp_q.push_back(ALL_OFF);
            end else begin
                m_edges++;
                exp_q.push_back(model_out(((m_edges - 1) / RD) % 4));
                if (m_edges % FRAME == 0) begin
                    m_frames++;
                    {m_mode, m_vote, m_cand, m_tens, m_ones, m_ov} =
                        {result_mode, vote, cand, tens, ones, overflow};
                    if (!overflow) m_bp = 1'b0;
                    else if (m_frames % BF == 0) m_bp = ~m_bp;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic chk_lit(input string name, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic e_dp);
        chk(name, {an, seg, dp}, {e_an, e_seg, e_dp});
    endtask

    // scoreboard compare on the falling edge
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cycle", {an, seg, dp}, e);
            end
        end
    end

    // returns at the falling edge where digit0 of a new frame is showing
    task automatic wait_frame_start();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME && !ok; i++) begin
            @(negedge clock);
            if (m_edges % FRAME == 1) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL frame_sync: no frame start within %0d clocks, edges=%0d", 2 * FRAME, m_edges);
        end
    endtask

    logic [13:0] vec [7];
    int          blanks;

    initial begin
        vec[0] = {1'b1, 4'b0000, 2'd0, 2'd3, 4'd9};
        vec[1] = {1'b1, 4'b0000, 2'd3, 2'd2, 4'd12};
        vec[2] = {1'b0, 4'b1000, 2'd0, 2'd0, 4'd0};
        vec[3] = {1'b0, 4'b0001, 2'd1, 2'd1, 4'd1};
        vec[4] = {1'b0, 4'b0000, 2'd0, 2'd0, 4'd0};
        vec[5] = {1'b0, 4'b1111, 2'd0, 2'd0, 4'd0};
        vec[6] = {1'b1, 4'b0000, 2'd1, 2'd0, 4'd0};

        // reset held, then released; first lit digit is digit0 dash
        repeat (3) @(negedge clock);
        chk_lit("reset_off", 4'hF, 7'h7F, 1'b1);
        reset_n = 1'b1;
        @(negedge clock);
        chk_lit("first_dash", 4'b1110, 7'b1111110, 1'b1);

        // result mode C,3.,1,7
        result_mode = 1'b1; cand = 2'd2; tens = 2'd1; ones = 4'd7;
        wait_frame_start();
        chk_lit("r_ones7", 4'b1110, 7'b0001111, 1'b1);
        repeat (3) @(negedge clock);
        chk_lit("r_ones7_held", 4'b1110, 7'b0001111, 1'b1);
        @(negedge clock);
        chk_lit("r_tens1", 4'b1101, 7'b1001111, 1'b1);
        repeat (4) @(negedge clock);
        chk_lit("r_cand3_dp", 4'b1011, 7'b0000110, 1'b0);
        repeat (4) @(negedge clock);
        chk_lit("r_c", 4'b0111, 7'b0110001, 1'b1);

        // tens zero blanks digit1 but keeps its anode
        tens = 2'd0; ones = 4'd5;
        wait_frame_start();
        chk_lit("r_ones5", 4'b1110, 7'b0100100, 1'b1);
        repeat (4) @(negedge clock);
        chk_lit("r_tens_blank", 4'b1101, 7'h7F, 1'b1);

        // vote mode, mid-frame changes wait for the next frame
        result_mode = 1'b0; vote = 4'b0100;
        wait_frame_start();
        chk_lit("v_three", 4'b1110, 7'b0000110, 1'b1);
        repeat (4) @(negedge clock);
        result_mode = 1'b1; vote = 4'b0110;
        repeat (8) @(negedge clock);
        chk_lit("v_midframe_p", 4'b0111, 7'b0011000, 1'b1);
        result_mode = 1'b0;
        wait_frame_start();
        chk_lit("v_multi_dash", 4'b1110, 7'b1111110, 1'b0);

        // directed vectors, one per frame, checked by the model
        for (int i = 0; i < 7; i++) begin
            {result_mode, vote, cand, tens, ones} = vec[i];
            wait_frame_start();
        end

        // overflow: blink (2 of every 4 frames dark) or steady dp
        result_mode = 1'b1; cand = 2'd1; tens = 2'd2; ones = 4'd3; overflow = 1'b1;
        wait_frame_start();
        blanks = 0;
        for (int f = 0; f < 4; f++) begin
            if (f > 0) wait_frame_start();
            if (an === 4'hF) blanks++;
`ifndef EVM_DISP_BLINK_EN
            chk_lit("ovf_dp_steady", 4'b1110, 7'b0000110, 1'b0);
`endif
        end
        checks++;
`ifdef EVM_DISP_BLINK_EN
        if (blanks != 2) begin
            errors++;
            $display("FAIL ovf_blank_frames: got %0d dark frames of 4, expected 2", blanks);
        end
`else
        if (blanks != 0) begin
            errors++;
            $display("FAIL ovf_blank_frames: got %0d dark frames of 4, expected 0", blanks);
        end
`endif
        overflow = 1'b0;
        wait_frame_start();
        chk_lit("ovf_cleared", 4'b1110, 7'b0000110, 1'b1);

        // async reset mid-digit, then resume from digit0 with the zero snapshot
        wait_frame_start();
        repeat (5) @(negedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 chk_lit("async_off", 4'hF, 7'h7F, 1'b1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk_lit("resume_dash", 4'b1110, 7'b1111110, 1'b1);
        repeat (2 * FRAME) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
